// File: rtl/load_mem_ctrl.sv
// load_mem_ctrl: sequences one data-memory read per load instruction.
//
// Computes the byte address rv1+imm, screens out illegal load widths (and,
// when LOAD_MISALIGN_TRAP_EN is defined, misaligned halfword/word loads),
// issues a word-aligned request, waits a bounded number of cycles for the
// read data, and hands the address, raw word, width code and error flag to
// the L-type stage with a one-cycle ld_valid_o pulse.
//
// Build option:
//   LOAD_MISALIGN_TRAP_EN  defined   -> misaligned LH/LHU/LW finish with ld_err_o=1
//                                       and no memory access
//                          undefined -> misaligned loads are issued normally
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  load request handshake (ready only in IDLE)
//   funct3_i, rv1_i, imm_i   load width code, base register, signed offset
//   mem_req_o, mem_addr_o    memory request strobe and word-aligned address
//   mem_gnt_i                memory accepted the request
//   mem_rvalid_i, mem_rdata_i  read data return
//   daddr_o, drdata_o, ld_funct3_o, ld_err_o  result to the L-type stage
//   ld_valid_o               one-cycle pulse marking the result valid
//
// state | meaning
// IDLE  | ready for a request; results from the last load are held
// REQ   | mem_req_o asserted, waiting for mem_gnt_i
// WAIT  | granted, counting cycles until mem_rvalid_i or timeout
// RESP  | ld_valid_o pulse, result outputs valid

module load_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rv1_i,
  input  logic [31:0] imm_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] daddr_o,
  output logic [31:0] drdata_o,
  output logic [2:0]  ld_funct3_o,
  output logic        ld_valid_o,
  output logic        ld_err_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   daddr_q, daddr_d;
  logic [31:0]   drdata_q, drdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          err_q, err_d;

  logic [31:0]   new_addr;
  logic          illegal_f3;
  logic          misalign;

  assign new_addr = rv1_i + imm_i;

  always_comb begin
    illegal_f3 = 1'b0;
    case (funct3_i)
      3'd3, 3'd6, 3'd7: illegal_f3 = 1'b1;
      default:          illegal_f3 = 1'b0;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  // LH/LHU share funct3[1:0]=01; LW is the only word load.
  assign misalign = ((funct3_i[1:0] == 2'b01) && new_addr[0]) ||
                    ((funct3_i == 3'd2) && (new_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    daddr_d  = daddr_q;
    drdata_d = drdata_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          daddr_d  = new_addr;
          funct3_d = funct3_i;
          drdata_d = '0;
          err_d    = 1'b0;
          if (illegal_f3 || misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = '0;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        // Read data wins over a timeout landing in the same cycle.
        if (mem_rvalid_i) begin
          drdata_d = mem_rdata_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          drdata_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      daddr_q  <= '0;
      drdata_q <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      daddr_q  <= daddr_d;
      drdata_q <= drdata_d;
      funct3_q <= funct3_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_addr_o  = {daddr_q[31:2], 2'b00};
  assign ld_valid_o  = (state_q == RESP);
  assign daddr_o     = daddr_q;
  assign drdata_o    = drdata_q;
  assign ld_funct3_o = funct3_q;
  assign ld_err_o    = err_q;

endmodule

// File: tb/tb_load_mem_ctrl.sv
module tb_load_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rv1_i = '0;
  logic [31:0] imm_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] daddr_o;
  logic [31:0] drdata_o;
  logic [2:0]  ld_funct3_o;
  logic        ld_valid_o;
  logic        ld_err_o;

  load_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .funct3_i(funct3_i), .rv1_i(rv1_i), .imm_i(imm_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .daddr_o(daddr_o), .drdata_o(drdata_o), .ld_funct3_o(ld_funct3_o),
    .ld_valid_o(ld_valid_o), .ld_err_o(ld_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rv1;
    logic [31:0] imm;
    int          gnt_dly;   // cycles mem_req is held before mem_gnt
    int          rv_dly;    // WAIT cycles before mem_rvalid; -1 = never
    logic [31:0] rdata;
    int          cyc;       // expected ld_valid cycle (request edge = 0)
    logic [31:0] daddr;
    logic [31:0] maddr;
    logic [31:0] drdata;
    logic        err;
    int          reqc;      // expected number of mem_req cycles
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] daddr;
    logic [31:0] drdata;
    logic [2:0]  f3;
    logic        err;
    int          reqc;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, req_cycles, wait_cycles;
    bit   in_wait, done;
    exp_t e;
    @(negedge clk_i);
    chk($sformatf("v%0d ready_before", idx), 32'(req_ready_o), 32'd1);
    chk($sformatf("v%0d valid_low_before", idx), 32'(ld_valid_o), 32'd0);
    req_valid_i = 1'b1;
    funct3_i = v.f3;
    rv1_i = v.rv1;
    imm_i = v.imm;
    e.cyc = v.cyc; e.daddr = v.daddr; e.drdata = v.drdata;
    e.f3 = v.f3; e.err = v.err; e.reqc = v.reqc;
    sb.push_back(e);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 1; req_cycles = 0; wait_cycles = 0; in_wait = 0; done = 0;
    while (!done && cyc < 60) begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      if (ld_valid_o) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL v%0d scoreboard: got ld_valid expected none", idx);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(e.cyc));
          chk($sformatf("v%0d daddr", idx), daddr_o, e.daddr);
          chk($sformatf("v%0d drdata", idx), drdata_o, e.drdata);
          chk($sformatf("v%0d ld_funct3", idx), 32'(ld_funct3_o), 32'(e.f3));
          chk($sformatf("v%0d ld_err", idx), 32'(ld_err_o), 32'(e.err));
          chk($sformatf("v%0d mem_req_cycles", idx), 32'(req_cycles), 32'(e.reqc));
        end
        done = 1;
      end else begin
        if (in_wait) begin
          wait_cycles++;
          if (v.rv_dly >= 0 && wait_cycles == v.rv_dly + 1) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = v.rdata;
          end
        end
        if (mem_req_o) begin
          chk($sformatf("v%0d mem_addr", idx), mem_addr_o, v.maddr);
          req_cycles++;
          if (req_cycles > v.gnt_dly) begin
            mem_gnt_i = 1'b1;
            in_wait = 1;
          end
        end
      end
      if (!done) begin
        @(negedge clk_i);
        cyc++;
      end
    end
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL v%0d ld_valid_timeout: got none expected pulse by cycle %0d", idx, v.cyc);
    end
  endtask

  initial begin
    int seen;
    //         f3    rv1            imm            g  rv  rdata          cyc daddr          maddr          drdata         err  reqc
    vecs[0] = '{3'd2, 32'h0010_0000, 32'h0000_0004, 0, 0, 32'hF1F2_F3F4, 3,  32'h0010_0004, 32'h0010_0004, 32'hF1F2_F3F4, 1'b0, 1};
    vecs[1] = '{3'd0, 32'h0010_0000, 32'h0000_0002, 3, 0, 32'h1122_3344, 6,  32'h0010_0002, 32'h0010_0000, 32'h1122_3344, 1'b0, 4};
    vecs[2] = '{3'd7, 32'h0010_0000, 32'h0000_0008, 0, 0, 32'h0,         1,  32'h0010_0008, 32'h0,         32'h0,         1'b1, 0};
    vecs[3] = '{3'd2, 32'h0000_2000, 32'h0000_0000, 0, -1, 32'h0,        18, 32'h0000_2000, 32'h0000_2000, 32'h0,         1'b1, 1};
    vecs[4] = '{3'd2, 32'h0000_3000, 32'h0000_0010, 0, 15, 32'hCAFE_BABE, 18, 32'h0000_3010, 32'h0000_3010, 32'hCAFE_BABE, 1'b0, 1};
`ifdef LOAD_MISALIGN_TRAP_EN
    vecs[5] = '{3'd1, 32'h0010_0000, 32'h0000_0003, 0, 1, 32'h55AA_55AA, 1,  32'h0010_0003, 32'h0010_0000, 32'h0,         1'b1, 0};
`else
    vecs[5] = '{3'd1, 32'h0010_0000, 32'h0000_0003, 0, 1, 32'h55AA_55AA, 4,  32'h0010_0003, 32'h0010_0000, 32'h55AA_55AA, 1'b0, 1};
`endif
    vecs[6] = '{3'd3, 32'h0000_0100, 32'h0000_0000, 0, 0, 32'h0,         1,  32'h0000_0100, 32'h0,         32'h0,         1'b1, 0};
    vecs[7] = '{3'd6, 32'h0000_0200, 32'hFFFF_FFFC, 0, 0, 32'h0,         1,  32'h0000_01FC, 32'h0,         32'h0,         1'b1, 0};
    vecs[8] = '{3'd4, 32'h0000_0010, 32'hFFFF_FFF0, 1, 2, 32'h0000_00A5, 6,  32'h0000_0000, 32'h0000_0000, 32'h0000_00A5, 1'b0, 2};
    vecs[9] = '{3'd5, 32'hFFFF_FFFE, 32'h0000_0004, 0, 0, 32'h89AB_CDEF, 3,  32'h0000_0002, 32'h0000_0000, 32'h89AB_CDEF, 1'b0, 1};
    vecs[10] = '{3'd2, 32'h0000_1000, 32'h0000_0008, 2, 4, 32'h1357_9BDF, 9, 32'h0000_1008, 32'h0000_1008, 32'h1357_9BDF, 1'b0, 3};

    // Reset is asynchronous: outputs must be cleared before any clock edge.
    #3;
    chk("rst mem_req", 32'(mem_req_o), 32'd0);
    chk("rst mem_addr", mem_addr_o, 32'd0);
    chk("rst daddr", daddr_o, 32'd0);
    chk("rst drdata", drdata_o, 32'd0);
    chk("rst ld_funct3", 32'(ld_funct3_o), 32'd0);
    chk("rst ld_valid", 32'(ld_valid_o), 32'd0);
    chk("rst ld_err", 32'(ld_err_o), 32'd0);
    chk("rst req_ready", 32'(req_ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Results hold in IDLE; a stray mem_rvalid there is ignored.
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h0BAD_0BAD;
    repeat (3) @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("hold ld_valid", 32'(ld_valid_o), 32'd0);
    chk("hold req_ready", 32'(req_ready_o), 32'd1);
    chk("hold daddr", daddr_o, 32'h0000_1008);
    chk("hold drdata", drdata_o, 32'h1357_9BDF);
    chk("hold ld_funct3", 32'(ld_funct3_o), 32'd2);
    chk("hold ld_err", 32'(ld_err_o), 32'd0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of WAIT abandons the load.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    funct3_i = 3'd2;
    rv1_i = 32'h0040_0000;
    imm_i = 32'h0000_000C;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("midrst mem_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("midrst daddr_before", daddr_o, 32'h0040_000C);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst mem_req0", 32'(mem_req_o), 32'd0);
    chk("midrst mem_addr0", mem_addr_o, 32'd0);
    chk("midrst daddr0", daddr_o, 32'd0);
    chk("midrst drdata0", drdata_o, 32'd0);
    chk("midrst ld_funct30", 32'(ld_funct3_o), 32'd0);
    chk("midrst ld_valid0", 32'(ld_valid_o), 32'd0);
    chk("midrst ld_err0", 32'(ld_err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (ld_valid_o) seen++;
    end
    chk("midrst no_ld_valid", 32'(seen), 32'd0);
    chk("midrst req_ready", 32'(req_ready_o), 32'd1);
    chk("midrst drdata_kept0", drdata_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_mem_ctrl.md
LOAD_MEM_CTRL -- requirements
Module: load_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles spent in WAIT before the request is abandoned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  load request from decode/execute.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 funct3  input  3  load width/sign code: LB=0, LH=1, LW=2, LBU=4, LHU=5.
REQ-007 rv1  input  32  base register value.
REQ-008 imm  input  32  signed immediate offset.
REQ-009 mem_req  output  1  data-memory request strobe.
REQ-010 mem_addr  output  32  word-aligned memory address.
REQ-011 mem_gnt  input  1  memory accepted mem_req.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rdata  input  32  read data word.
REQ-014 daddr  output  32  full byte address, passed to the L-type stage.
REQ-015 drdata  output  32  captured memory word, passed to the L-type stage.
REQ-016 ld_funct3  output  3  registered funct3, passed to the L-type stage.
REQ-017 ld_valid  output  1  one-cycle pulse: daddr/drdata/ld_funct3/ld_err are valid.
REQ-018 ld_err  output  1  load failed: misaligned, illegal funct3, or timeout.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP.
REQ-020 In IDLE, req_valid high: the block SHALL register funct3, daddr = rv1+imm (mod 2^32, carry discarded), and check legality.
REQ-021 funct3 in {3,6,7}: no memory access; next state RESP with ld_err=1 and drdata=0.
REQ-022 Legal request: next state REQ.
REQ-023 REQ: mem_req=1; mem_addr={daddr[31:2],2'b00}, held stable until mem_gnt; on mem_gnt, next state WAIT.
REQ-024 WAIT: mem_req=0; a cycle counter increments each cycle; on mem_rvalid, drdata captures mem_rdata and next state is RESP with ld_err=0.
REQ-025 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without mem_rvalid, next state RESP with ld_err=1 and drdata=0.
REQ-026 mem_rvalid and timeout in the same cycle: mem_rvalid wins and no error is raised.
REQ-027 mem_rvalid in IDLE, REQ or RESP is ignored.
REQ-028 RESP: ld_valid=1 for exactly one cycle; next state IDLE; the counter clears.
REQ-029 daddr, drdata, ld_funct3 and ld_err hold their values from RESP until the next request is accepted.
REQ-030 Latency with a zero-wait memory (mem_gnt in the same cycle as mem_req, mem_rvalid one cycle later): request accepted at edge 0, ld_valid high in cycle 3.
REQ-031 Back-to-back: a new request is accepted in the IDLE cycle after RESP; throughput is 1 load per 4 cycles minimum.

Reset
REQ-032 Reset low: state=IDLE, counter=0, mem_req=0, mem_addr=0, daddr=0, drdata=0, ld_funct3=0, ld_valid=0, ld_err=0, applied immediately regardless of clk.
REQ-033 Reset asserted mid-transaction: the transaction is abandoned, no ld_valid is produced, and a late mem_rvalid after reset release is ignored.

Configuration
REQ-034 Macro LOAD_MISALIGN_TRAP_EN defined: LH/LHU with daddr[0]=1, or LW with daddr[1:0]!=0, skips memory access and goes to RESP with ld_err=1.
REQ-035 Macro undefined: misaligned addresses are issued normally (word-aligned mem_addr) with ld_err=0; lane selection is left to the L-type stage.

Verification
REQ-036 Zero-wait memory; LW, rv1=0x00100000, imm=4, mem_rdata=0xF1F2F3F4 -> mem_addr=0x00100004; cycle 3 ld_valid=1, drdata=0xF1F2F3F4, ld_err=0.
REQ-037 LB, rv1=0x00100000, imm=2; mem_gnt delayed 3 cycles -> mem_req and mem_addr=0x00100000 held 4 cycles; daddr=0x00100002; ld_valid in cycle 6.
REQ-038 LW, no mem_rvalid, TIMEOUT_CYCLES=16 -> ld_valid with ld_err=1 and drdata=0 after 16 WAIT cycles; mem_rvalid in the final WAIT cycle -> ld_err=0.
REQ-039 LH at daddr=0x00100003 -> with LOAD_MISALIGN_TRAP_EN: mem_req never asserted, ld_err=1 in cycle 1; without it: normal access, ld_err=0.
REQ-040 funct3=7 -> no mem_req, ld_valid with ld_err=1; next, reset pulled low during WAIT -> all outputs 0 at once, no ld_valid, req_ready=1 after release.
